// File: rtl/axi_wr_pkg.sv
// Shared defaults and helpers for the AXI write-data router.
package axi_wr_pkg;
   localparam int NUM_SLAVES_DEF  = 3;
   localparam int ROUTE_DEPTH_DEF = 4;
   localparam int DATA_BITS_DEF   = 32;

   // One extra code point is reserved for the default (decode-error) slave.
   function automatic int slv_width(input int num_slaves);
      return $clog2(num_slaves + 1);
   endfunction
endpackage

// File: rtl/route_fifo.sv
// Route queue: holds the destination of each accepted AW until its W burst completes.
module route_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      count,
   output logic             ovf
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   // A pop in the same cycle frees the slot, so a push while full is still legal.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && full && !pop) ovf <= 1'b1;
      end
   end
endmodule

// File: rtl/axi_wdata_router.sv
// Steers the master W channel to the slave chosen by the oldest outstanding AW.
module axi_wdata_router
   import axi_wr_pkg::*;
#(
   parameter int  NUM_SLAVES  = NUM_SLAVES_DEF,
   parameter int  ROUTE_DEPTH = ROUTE_DEPTH_DEF,
   parameter int  DATA_BITS   = DATA_BITS_DEF,
   localparam int STRB_BITS   = DATA_BITS / 8,
   localparam int SLV_W       = slv_width(NUM_SLAVES)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            aw_push,
   input  logic [SLV_W-1:0]                aw_slv,
   output logic                            aw_full,
   input  logic [DATA_BITS-1:0]            wdata_m,
   input  logic [STRB_BITS-1:0]            wstrb_m,
   input  logic                            wlast_m,
   input  logic                            wvalid_m,
   output logic                            wready_m,
   output logic [NUM_SLAVES*DATA_BITS-1:0] wdata_s,
   output logic [NUM_SLAVES*STRB_BITS-1:0] wstrb_s,
   output logic [NUM_SLAVES-1:0]           wlast_s,
   output logic [NUM_SLAVES-1:0]           wvalid_s,
   input  logic [NUM_SLAVES-1:0]           wready_s,
   output logic                            derr_done,
   output logic                            ovf_err
);
   localparam int PW = $clog2(ROUTE_DEPTH);

   logic [SLV_W-1:0] head;
   logic             empty;
   logic             full;
   logic [PW:0]      count;
   logic             dflt_sel;
   logic             pop;

   route_fifo #(.WIDTH(SLV_W), .DEPTH(ROUTE_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (aw_push),
      .din   (aw_slv),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count),
      .ovf   (ovf_err)
   );

   assign aw_full = full;
   assign wdata_s = {NUM_SLAVES{wdata_m}};
   assign wlast_s = {NUM_SLAVES{wlast_m}};
   assign pop     = wvalid_m && wready_m && wlast_m;

   // Any head index past the real slaves is treated as the default slave.
   always_comb begin
      wready_m = 1'b0;
      wvalid_s = '0;
      wstrb_s  = '0;
      dflt_sel = 1'b0;
      if (!empty) begin
         dflt_sel = (head >= SLV_W'(NUM_SLAVES));
         if (dflt_sel) wready_m = 1'b1;
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (head == SLV_W'(i)) begin
               wvalid_s[i]                          = wvalid_m;
               wready_m                             = wready_s[i];
               wstrb_s[i*STRB_BITS +: STRB_BITS]    = wstrb_m;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) derr_done <= 1'b0;
      else     derr_done <= pop && dflt_sel;
   end
endmodule

// File: tb/tb_axi_wdata_router.sv
// Scoreboard bench for axi_wdata_router: directed bursts, monitor checks every accepted beat.
module tb_axi_wdata_router;
   localparam int NS = 3;
   localparam int DB = 32;
   localparam int SB = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            aw_push = 1'b0;
   logic [SW-1:0]   aw_slv = '0;
   logic            aw_full;
   logic [DB-1:0]   wdata_m = '0;
   logic [SB-1:0]   wstrb_m = '0;
   logic            wlast_m = 1'b0;
   logic            wvalid_m = 1'b0;
   logic            wready_m;
   logic [NS*DB-1:0] wdata_s;
   logic [NS*SB-1:0] wstrb_s;
   logic [NS-1:0]   wlast_s;
   logic [NS-1:0]   wvalid_s;
   logic [NS-1:0]   wready_s = '1;
   logic            derr_done;
   logic            ovf_err;

   axi_wdata_router dut (
      .clk(clk), .rst(rst), .aw_push(aw_push), .aw_slv(aw_slv), .aw_full(aw_full),
      .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m), .wvalid_m(wvalid_m),
      .wready_m(wready_m), .wdata_s(wdata_s), .wstrb_s(wstrb_s), .wlast_s(wlast_s),
      .wvalid_s(wvalid_s), .wready_s(wready_s), .derr_done(derr_done), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            slv;
      logic [DB-1:0] data;
      logic [SB-1:0] strb;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    derr_cnt = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat is matched against the oldest expected beat.
   always @(negedge clk) begin
      beat_t e;
      logic [NS*SB-1:0] es;
      logic [NS-1:0]    ev;
      if (derr_done) derr_cnt++;
      if (!rst && wvalid_m && wready_m) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            e  = exp_q.pop_front();
            es = '0;
            ev = '0;
            if (e.slv < NS) begin
               es = (NS*SB)'(e.strb) << (e.slv * SB);
               ev = NS'(1) << e.slv;
            end
            chk("beat_wvalid_s", wvalid_s, ev);
            chk("beat_wstrb_s", wstrb_s, es);
            chk("beat_wdata_s", wdata_s, {NS{e.data}});
            chk("beat_wlast_s", wlast_s, {NS{e.last}});
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      wvalid_m = 1'b0;
      aw_push = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic push_route(input int s);
      aw_push = 1'b1;
      aw_slv  = SW'(s);
      @(posedge clk);
      #1 aw_push = 1'b0;
   endtask

   task automatic send_beat(input int s, input logic [DB-1:0] d, input logic [SB-1:0] st,
                            input logic l, output int waits);
      beat_t e;
      e.slv = s; e.data = d; e.strb = st; e.last = l;
      exp_q.push_back(e);
      wvalid_m = 1'b1; wdata_m = d; wstrb_m = st; wlast_m = l;
      waits = 0;
      forever begin
         @(negedge clk);
         if (wready_m) break;
         waits++;
         if (waits > 50) begin
            chk("beat_timeout", waits, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wvalid_m = 1'b0;
      wlast_m  = 1'b0;
   endtask

   initial begin
      int w;
      beat_t e;
      int rt[4];

      // Reset state
      #3;
      chk("rst_wready_m", wready_m, 0);
      chk("rst_wvalid_s", wvalid_s, 0);
      chk("rst_aw_full", aw_full, 0);
      chk("rst_derr", derr_done, 0);
      chk("rst_ovf", ovf_err, 0);
      do_reset();

      // Two-beat burst to slave 1
      push_route(1);
      send_beat(1, 32'h1111_0001, 4'hf, 1'b0, w);
      send_beat(1, 32'h1111_0002, 4'h3, 1'b1, w);
      idle();
      chk("b1_empty_after", wready_m, 0);

      // Three queued one-beat bursts stream without gaps
      push_route(0);
      push_route(2);
      push_route(1);
      rt = '{0, 2, 1, 0};
      for (int i = 0; i < 3; i++) begin
         send_beat(rt[i], 32'hA000_0000 + DB'(i), 4'h5, 1'b1, w);
         chk("stream_gap", w, 0);
      end
      idle();

      // Default slave burst: always ready, DECERR pulse after last
      push_route(3);
      for (int i = 0; i < 4; i++) begin
         send_beat(3, 32'hDEAD_0000 + DB'(i), 4'hf, i == 3, w);
         chk("dflt_ready", w, 0);
      end
      idle();
      chk("derr_pulse", derr_done, 1);
      @(posedge clk); #1;
      chk("derr_one_cycle", derr_done, 0);

      // Overflow: fifth push while full without pop is lost
      do_reset();
      for (int i = 0; i < 4; i++) push_route(0);
      chk("full_after_4", aw_full, 1);
      push_route(1);
      chk("ovf_set", ovf_err, 1);
      chk("still_full", aw_full, 1);
      for (int i = 0; i < 4; i++) send_beat(0, 32'hB000_0000 + DB'(i), 4'h1, 1'b1, w);
      idle();
      @(negedge clk);
      chk("fifth_lost", wready_m, 0);
      chk("ovf_sticky", ovf_err, 1);

      // Push with simultaneous last-beat pop while full
      do_reset();
      for (int i = 0; i < 4; i++) push_route(2);
      e.slv = 2; e.data = 32'hC0DE_0001; e.strb = 4'h8; e.last = 1'b1;
      exp_q.push_back(e);
      wvalid_m = 1'b1; wdata_m = e.data; wstrb_m = e.strb; wlast_m = 1'b1;
      aw_push = 1'b1; aw_slv = 2'd1;
      @(posedge clk);
      #1 aw_push = 1'b0;
      idle();
      chk("pushpop_full", aw_full, 1);
      chk("pushpop_no_ovf", ovf_err, 0);
      rt = '{2, 2, 2, 1};
      for (int i = 0; i < 4; i++) send_beat(rt[i], 32'hC0DE_0010 + DB'(i), 4'h2, 1'b1, w);
      idle();
      @(negedge clk);
      chk("pushpop_drained", wready_m, 0);

      // Slave 0 back-pressure for three cycles
      push_route(0);
      wready_s = 3'b110;
      wvalid_m = 1'b1; wdata_m = 32'h5717_0000; wstrb_m = 4'hc; wlast_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_wready_m", wready_m, 0);
         chk("stall_wvalid_s", wvalid_s, 3'b001);
         chk("stall_data", wdata_s[DB-1:0], 32'h5717_0000);
      end
      @(posedge clk); #1;
      e.slv = 0; e.data = 32'h5717_0000; e.strb = 4'hc; e.last = 1'b1;
      exp_q.push_back(e);
      wready_s = 3'b111;
      @(negedge clk);
      @(posedge clk); #1;
      idle();

      // Reset mid-burst flushes queued routes
      push_route(1);
      push_route(2);
      send_beat(1, 32'hE000_0001, 4'hf, 1'b0, w);
      wdata_m = 32'hE000_0002; wlast_m = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("midrst_wready_m", wready_m, 0);
      chk("midrst_wvalid_s", wvalid_s, 0);
      chk("midrst_aw_full", aw_full, 0);
      chk("midrst_derr", derr_done, 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("postrst_wait", {wready_m, wvalid_s}, 0);
      end
      @(posedge clk); #1;
      push_route(0);
      send_beat(0, 32'hE000_0003, 4'h9, 1'b1, w);
      idle();

      repeat (2) @(posedge clk);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("derr_total", derr_cnt, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/axi_wdata_router.md
AXI_WDATA_ROUTER -- requirements
Module: axi_wdata_router

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 3, giving the number of real slave ports.
REQ-002 The block SHALL have parameter ROUTE_DEPTH, default 4, giving the maximum number of outstanding write bursts; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter DATA_BITS, default 32, giving the W data width; STRB_BITS is fixed at DATA_BITS/8.
REQ-004 The block SHALL derive SLV_W = $clog2(NUM_SLAVES+1), the width of a route index.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 The ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- aw_push  in  1  AW handshake completed this cycle
- aw_slv  in  SLV_W  destination index; value NUM_SLAVES selects the default (decode-error) slave
- aw_full  out  1  route queue full; the AW arbiter must not accept a new AW
- wdata_m  in  DATA_BITS  master write data
- wstrb_m  in  STRB_BITS  master write strobe
- wlast_m  in  1  master last beat
- wvalid_m  in  1  master valid
- wready_m  out  1  master ready
- wdata_s  out  NUM_SLAVES*DATA_BITS  per-slave write data
- wstrb_s  out  NUM_SLAVES*STRB_BITS  per-slave write strobe
- wlast_s  out  NUM_SLAVES  per-slave last
- wvalid_s  out  NUM_SLAVES  per-slave valid
- wready_s  in  NUM_SLAVES  per-slave ready
- derr_done  out  1  one-cycle pulse when a default-slave burst completes; drives DECERR on B
- ovf_err  out  1  sticky flag: push attempted while full

Function
REQ-010 Each aw_push SHALL enqueue aw_slv into a FIFO of ROUTE_DEPTH entries; a route becomes usable on the following cycle, so there is no same-cycle bypass.
REQ-011 The active route SHALL be the FIFO head; with the FIFO empty, wready_m = 0 and all wvalid_s = 0.
REQ-012 With head h < NUM_SLAVES:
- wvalid_s[h] = wvalid_m
- wready_m = wready_s[h]
- every other wvalid_s bit = 0
REQ-013 Routing of W to the slave SHALL be combinational, with zero latency.
REQ-014 wdata_s and wlast_s SHALL broadcast the master values to all slices.
REQ-015 wstrb_s SHALL carry wstrb_m on the selected slice and all zeros on every other slice.
REQ-016 With head h = NUM_SLAVES (default slave), the block SHALL assert wready_m = 1, keep all wvalid_s = 0, and discard the data.
REQ-017 A beat is accepted when wvalid_m and wready_m are both 1; an accepted beat with wlast_m = 1 SHALL pop the FIFO at that clock edge.
REQ-018 An accepted last beat on the default slave SHALL pulse derr_done high for exactly the next cycle.
REQ-019 When push and pop occur in the same cycle:
- the occupancy count SHALL stay unchanged
- this SHALL be legal even when the FIFO is full, because the pop frees the slot.
REQ-020 aw_full SHALL equal (count == ROUTE_DEPTH).
REQ-021 A push while full without a same-cycle pop SHALL be dropped and SHALL set ovf_err, which holds until reset.
REQ-022 Read and write pointers SHALL be log2(ROUTE_DEPTH) bits wide and wrap modulo ROUTE_DEPTH; count SHALL be log2(ROUTE_DEPTH)+1 bits wide.
REQ-023 A beat with wlast_m = 0 SHALL NOT change the FIFO, and back-to-back bursts SHALL stream with no idle cycle between them.

Reset
REQ-030 While rst is high, the block SHALL hold: pointers and count = 0, aw_full = 0, wready_m = 0, wvalid_s = 0, derr_done = 0, ovf_err = 0.
REQ-031 Reset asserted mid-burst SHALL flush all queued routes immediately (asynchronously), with no beat forwarded after assertion.

Structure
REQ-040 The package axi_wr_pkg SHALL hold the default parameter values and a function that computes SLV_W.
REQ-041 The route queue SHALL be a separate sub-module, route_fifo, parametrised by width and depth, providing push, pop, head, full, empty, count and ovf.
REQ-042 The top level SHALL contain only the W mux/demux, pop generation and the derr_done register.

Verification
REQ-050 Reset, then push aw_slv=1, then send 2 beats (strb 4'hf, then 4'h3 with last):
- wvalid_s = 3'b010
- wstrb_s slices 0 and 2 = 0
- FIFO empty after the last beat
REQ-051 Push routes 0, 2, 1 in consecutive cycles, then stream three 1-beat bursts: the bursts reach slaves 0, 2, 1 in order with no gap cycles.
REQ-052 Push aw_slv=3 (default slave), then send a 4-beat burst:
- wready_m = 1 on all beats
- no wvalid_s asserted
- derr_done high for exactly one cycle after the last beat
REQ-053 Push 4 routes (aw_full = 1), then a 5th push with no pop: ovf_err = 1 and the 5th route is lost; repeat with a simultaneous last-beat pop: count stays 4 and ovf_err stays 0.
REQ-054 Hold wready_s[0] = 0 for 3 cycles during a burst to slave 0: wready_m = 0 for those cycles and the data stays stable at the slave.
REQ-055 Assert rst mid-burst with 2 routes queued: outputs return to their reset values in the same cycle, and a subsequent burst waits for a new aw_push.
